// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART 8N1/8N2 transmitter draining a registered-output TX FIFO
//
// Pops one byte per frame from the TX FIFO and serialises it LSB-first as
// start bit, DATA_WIDTH data bits, STOP_BITS stop bits.
//
// Ports:
//   clk              - single clock, rising edge
//   rst              - asynchronous active-low reset
//   enable_in        - permits starting a new frame (sampled in IDLE / end of STOP)
//   fifo_data_in     - FIFO data_out, valid the cycle after a pop
//   fifo_empty_in    - FIFO empty flag
//   fifo_read_en_out - one-cycle pop strobe to the FIFO
//   tx_out           - serial line, idles high
//   busy_out         - high whenever the FSM is not in IDLE
//   frame_done_out   - one-cycle pulse in the final cycle of the last stop bit

module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_in,
    input  logic [DATA_WIDTH-1:0] fifo_data_in,
    input  logic                  fifo_empty_in,
    output logic                  fifo_read_en_out,
    output logic                  tx_out,
    output logic                  busy_out,
    output logic                  frame_done_out
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    // frame_done_out is registered, so it is set one cycle ahead of the
    // final stop-bit cycle.
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t                state;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  stop_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  start_ok;

    assign shift_next = shift >> 1;
    assign start_ok   = enable_in && !fifo_empty_in;

    // tx_out is loaded with the level of the state being entered, so it is
    // always a flop output and changes exactly on the bit boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            baud_cnt         <= '0;
            bit_cnt          <= '0;
            stop_cnt         <= 1'b0;
            shift            <= '0;
            tx_out           <= 1'b1;
            fifo_read_en_out <= 1'b0;
            busy_out         <= 1'b0;
            frame_done_out   <= 1'b0;
        end else begin
            fifo_read_en_out <= 1'b0;
            frame_done_out   <= 1'b0;
            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (start_ok) begin
                        state            <= POP;
                        fifo_read_en_out <= 1'b1;
                        busy_out         <= 1'b1;
                    end
                end
                POP: begin
                    // FIFO output is registered: data appears next cycle.
                    state <= LOAD;
                end
                LOAD: begin
                    shift    <= fifo_data_in;
                    baud_cnt <= '0;
                    tx_out   <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_out   <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        shift    <= shift_next;
                        if (bit_cnt == BIT_LAST) begin
                            stop_cnt <= 1'b0;
                            tx_out   <= 1'b1;
                            state    <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_out  <= shift_next[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx_out <= 1'b1;
                    if (baud_cnt == BAUD_PRE && stop_cnt == STOP_LAST) begin
                        frame_done_out <= 1'b1;
                    end
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (stop_cnt == STOP_LAST) begin
                            stop_cnt <= 1'b0;
                            if (start_ok) begin
                                state            <= POP;
                                fifo_read_en_out <= 1'b1;
                            end else begin
                                state    <= IDLE;
                                busy_out <= 1'b0;
                            end
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_out   <= 1'b1;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic enable = 1'b1;

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // FIFO model A (STOP_BITS=1 instance)
    logic [7:0] mem_a [0:15];
    int         wr_a = 0;
    int         rp_a = 0;
    logic [7:0] fd_a = 8'h00;
    logic       empty_a;
    logic       rd_a, tx_a, busy_a, done_a;

    // FIFO model B (STOP_BITS=2 instance)
    logic [7:0] mem_b [0:15];
    int         wr_b = 0;
    int         rp_b = 0;
    logic [7:0] fd_b = 8'h00;
    logic       empty_b;
    logic       rd_b, tx_b, busy_b, done_b;

    assign empty_a = (wr_a == rp_a);
    assign empty_b = (wr_b == rp_b);

    always @(posedge clk) begin
        if (rd_a) begin
            fd_a <= mem_a[rp_a[3:0]];
            rp_a <= rp_a + 1;
        end
        if (rd_b) begin
            fd_b <= mem_b[rp_b[3:0]];
            rp_b <= rp_b + 1;
        end
    end

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
        .clk              (clk),
        .rst              (rst),
        .enable_in        (enable),
        .fifo_data_in     (fd_a),
        .fifo_empty_in    (empty_a),
        .fifo_read_en_out (rd_a),
        .tx_out           (tx_a),
        .busy_out         (busy_a),
        .frame_done_out   (done_a)
    );

    uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
        .clk              (clk),
        .rst              (rst),
        .enable_in        (enable),
        .fifo_data_in     (fd_b),
        .fifo_empty_in    (empty_b),
        .fifo_read_en_out (rd_b),
        .tx_out           (tx_b),
        .busy_out         (busy_b),
        .frame_done_out   (done_b)
    );

    // Underflow pops and back-to-back pop strobes, counted every cycle.
    int   mon_errs = 0;
    logic prev_a   = 1'b0;
    logic prev_b   = 1'b0;
    always @(negedge clk) begin
        if ((rd_a && empty_a) || (rd_b && empty_b) || (rd_a && prev_a) || (rd_b && prev_b))
            mon_errs <= mon_errs + 1;
        prev_a <= rd_a;
        prev_b <= rd_b;
    end

    // Expected line level for a frame whose start bit begins at cycle 'start',
    // CLKS_PER_BIT=4; cycles before the start and after the data bits are high.
    function automatic logic exp_line(input int c, input int start, input logic [7:0] b);
        int rel;
        rel = c - start;
        if (rel < 0)  return 1'b1;
        if (rel < 4)  return 1'b0;
        if (rel < 36) return b[3'((rel - 4) / 4)];
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        // Reset held with a non-empty FIFO and enable high.
        rst      = 1'b0;
        enable   = 1'b1;
        mem_a[0] = 8'hA5;
        wr_a     = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_tx", tx_a, 1'b1);
            check("rst_rd", rd_a, 1'b0);
            check("rst_busy", busy_a, 1'b0);
            check("rst_done", done_a, 1'b0);
        end

        // Single byte 0xA5, STOP_BITS=1. Release is cycle 0.
        rst = 1'b1;
        for (int c = 1; c <= 44; c++) begin
            @(negedge clk);
            check("a5_tx", tx_a, exp_line(c, 3, 8'hA5));
            check("a5_rd", rd_a, c == 1);
            check("a5_done", done_a, c == 42);
            check("a5_busy", busy_a, c <= 42);
        end
        check_int("a5_pops", rp_a, 1);

        // Back-to-back 0x00, 0xFF with STOP_BITS=2: 44-cycle frames, 2 idle-high gap cycles.
        mem_b[0] = 8'h00;
        mem_b[1] = 8'hFF;
        wr_b     = 2;
        for (int c = 1; c <= 94; c++) begin
            @(negedge clk);
            check("b2b_tx", tx_b, (c < 49) ? exp_line(c, 3, 8'h00) : exp_line(c, 49, 8'hFF));
            check("b2b_rd", rd_b, (c == 1) || (c == 47));
            check("b2b_done", done_b, (c == 46) || (c == 92));
            check("b2b_busy", busy_b, c <= 92);
        end
        check_int("b2b_pops", rp_b, 2);
        check("b2b_empty", empty_b, 1'b1);

        // Empty FIFO with enable high: nothing happens.
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check("empty_rd", rd_a, 1'b0);
            check("empty_tx", tx_a, 1'b1);
            check("empty_busy", busy_a, 1'b0);
        end

        // Enable dropped mid-DATA with three bytes queued.
        mem_a[1] = 8'h11;
        mem_a[2] = 8'h22;
        mem_a[3] = 8'h33;
        wr_a     = 4;
        for (int c = 1; c <= 43; c++) begin
            @(negedge clk);
            check("gate_tx", tx_a, exp_line(c, 3, 8'h11));
            check("gate_rd", rd_a, c == 1);
            check("gate_done", done_a, c == 42);
            check("gate_busy", busy_a, c <= 42);
            if (c == 20) enable = 1'b0;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("gated_rd", rd_a, 1'b0);
            check("gated_busy", busy_a, 1'b0);
            check("gated_tx", tx_a, 1'b1);
        end
        check_int("gated_pops", rp_a, 2);

        // Re-enable: remaining bytes 0x22 then 0x33 back-to-back.
        enable = 1'b1;
        for (int c = 1; c <= 86; c++) begin
            @(negedge clk);
            check("reen_tx", tx_a, (c < 45) ? exp_line(c, 3, 8'h22) : exp_line(c, 45, 8'h33));
            check("reen_rd", rd_a, (c == 1) || (c == 43));
            check("reen_done", done_a, (c == 42) || (c == 84));
            check("reen_busy", busy_a, c <= 84);
        end
        check_int("reen_pops", rp_a, 4);

        // Reset during DATA bit 4 (a 0 bit of 0x2F).
        mem_a[4] = 8'h2F;
        wr_a     = 5;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            check("mid_tx", tx_a, exp_line(c, 3, 8'h2F));
        end
        rst = 1'b0;
        #1;
        check("async_tx", tx_a, 1'b1);
        check("async_busy", busy_a, 1'b0);
        check("async_rd", rd_a, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("post_rd", rd_a, 1'b0);
            check("post_busy", busy_a, 1'b0);
            check("post_tx", tx_a, 1'b1);
        end
        check_int("post_pops", rp_a, 5);
        check("post_empty", empty_a, 1'b1);

        check_int("pop_monitor", mon_errs, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
